// File: rtl/cnn_regs_pkg.sv
// cnn_regs_pkg: register map, response codes and field indices of the CNN register block
package cnn_regs_pkg;
  localparam logic [7:0] OFS_CONTROL     = 8'h00;
  localparam logic [7:0] OFS_STATUS      = 8'h04;
  localparam logic [7:0] OFS_FRAME_COUNT = 8'h08;
  localparam logic [7:0] OFS_ERROR_CODE  = 8'h0C;
  localparam logic [7:0] OFS_IRQ_STATUS  = 8'h10;
  localparam logic [7:0] OFS_IRQ_ENABLE  = 8'h14;
  localparam logic [7:0] OFS_SCRATCH     = 8'h18;
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam int CTRL_CNN_START = 0;
  localparam int CTRL_CNN_RESET = 1;
  localparam int IRQ_FRAME_DONE = 0;
  localparam int IRQ_ERROR      = 1;
endpackage

// File: rtl/cnn_ctrl_pulse_stretch.sv
// cnn_ctrl_pulse_stretch: self-clearing control bit held high PULSE_CYCLES cycles after set
module cnn_ctrl_pulse_stretch #(
  parameter int PULSE_CYCLES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic set,
  input  logic clr,
  output logic level
);
  logic [3:0] cnt;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt <= '0;
    else cnt <= set ? 4'(PULSE_CYCLES) : clr ? 4'd0 : cnt - {3'd0, |cnt};
  assign level = |cnt;
endmodule

// File: rtl/cnn_axi_lite_regs.sv
// cnn_axi_lite_regs: AXI4-Lite slave register front-end between the host and the CNN control logic
module cnn_axi_lite_regs
  import cnn_regs_pkg::*;
#(
  parameter int          ADDR_W        = 5,
  parameter int          PULSE_CYCLES  = 2,
  parameter logic [31:0] SCRATCH_RESET = 32'h0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] s_axi_awaddr,
  input  logic              s_axi_awvalid,
  output logic              s_axi_awready,
  input  logic [31:0]       s_axi_wdata,
  input  logic [3:0]        s_axi_wstrb,
  input  logic              s_axi_wvalid,
  output logic              s_axi_wready,
  output logic [1:0]        s_axi_bresp,
  output logic              s_axi_bvalid,
  input  logic              s_axi_bready,
  input  logic [ADDR_W-1:0] s_axi_araddr,
  input  logic              s_axi_arvalid,
  output logic              s_axi_arready,
  output logic [31:0]       s_axi_rdata,
  output logic [1:0]        s_axi_rresp,
  output logic              s_axi_rvalid,
  input  logic              s_axi_rready,
  output logic [31:0]       control_reg,
  input  logic [31:0]       status_reg,
  input  logic [31:0]       frame_count_reg,
  input  logic [31:0]       error_code_reg,
  output logic              irq
);
  localparam int W = ADDR_W - 2;
  function automatic logic hit(input logic [W-1:0] a, input logic [7:0] o);
    return a == W'(o >> 2);
  endfunction
  logic up, aw_held, w_held, ec_nz, start, cnn_rst, rd_err, unused;
  logic [W-1:0] aw_q, ri;
  logic [31:0] w_q, bm, rd_data, scratch, fc_q;
  logic [3:0] s_q;
  logic [29:0] ctrl_hi;
  logic [1:0] irq_st, irq_en, irq_set;
  logic do_wr, wr_ctrl, wr_ist, wr_ien, wr_scr;
  assign unused = ^{s_axi_awaddr[1:0], s_axi_araddr[1:0]};
  // up masks the readies while in reset and for the first cycle after release
  assign s_axi_awready = up && !aw_held && !s_axi_bvalid;
  assign s_axi_wready  = up && !w_held && !s_axi_bvalid;
  assign s_axi_arready = up && !s_axi_rvalid;
  assign do_wr   = aw_held && w_held;
  assign wr_ctrl = do_wr && hit(aw_q, OFS_CONTROL);
  assign wr_ist  = do_wr && hit(aw_q, OFS_IRQ_STATUS);
  assign wr_ien  = do_wr && hit(aw_q, OFS_IRQ_ENABLE);
  assign wr_scr  = do_wr && hit(aw_q, OFS_SCRATCH);
  assign bm = {{8{s_q[3]}}, {8{s_q[2]}}, {8{s_q[1]}}, {8{s_q[0]}}};
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      up <= 1'b0;
      aw_held <= 1'b0;
      w_held <= 1'b0;
      aw_q <= '0;
      w_q <= '0;
      s_q <= '0;
      s_axi_bvalid <= 1'b0;
      s_axi_bresp <= RESP_OKAY;
    end else begin
      up <= 1'b1;
      if (s_axi_awvalid && s_axi_awready) begin
        aw_held <= 1'b1;
        aw_q <= s_axi_awaddr[ADDR_W-1:2];
      end
      if (s_axi_wvalid && s_axi_wready) begin
        w_held <= 1'b1;
        w_q <= s_axi_wdata;
        s_q <= s_axi_wstrb;
      end
      if (do_wr) begin
        aw_held <= 1'b0;
        w_held <= 1'b0;
        s_axi_bvalid <= 1'b1;
        s_axi_bresp <= aw_q > W'(OFS_SCRATCH >> 2) ? RESP_SLVERR : RESP_OKAY;
      end else if (s_axi_bready) s_axi_bvalid <= 1'b0;
    end
  cnn_ctrl_pulse_stretch #(.PULSE_CYCLES(PULSE_CYCLES)) u_start (
    .clk(clk), .rst_n(rst_n),
    .set(wr_ctrl && s_q[0] && w_q[CTRL_CNN_START]),
    .clr(wr_ctrl && s_q[0] && !w_q[CTRL_CNN_START]),
    .level(start)
  );
  cnn_ctrl_pulse_stretch #(.PULSE_CYCLES(PULSE_CYCLES)) u_reset (
    .clk(clk), .rst_n(rst_n),
    .set(wr_ctrl && s_q[0] && w_q[CTRL_CNN_RESET]),
    .clr(wr_ctrl && s_q[0] && !w_q[CTRL_CNN_RESET]),
    .level(cnn_rst)
  );
  always_comb begin
    control_reg = {ctrl_hi, 2'b00};
    control_reg[CTRL_CNN_START] = start;
    control_reg[CTRL_CNN_RESET] = cnn_rst;
    irq_set = '0;
    irq_set[IRQ_FRAME_DONE] = frame_count_reg != fc_q;
    irq_set[IRQ_ERROR] = |error_code_reg && !ec_nz;
  end
  // a hardware set is OR-ed in after the W1C mask so it wins a same-cycle clear
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      ctrl_hi <= '0;
      irq_st <= '0;
      irq_en <= '0;
      scratch <= SCRATCH_RESET;
      fc_q <= '0;
      ec_nz <= 1'b0;
      irq <= 1'b0;
    end else begin
      if (wr_ctrl) ctrl_hi <= (ctrl_hi & ~bm[31:2]) | (w_q[31:2] & bm[31:2]);
      if (wr_ien) irq_en <= (irq_en & ~bm[1:0]) | (w_q[1:0] & bm[1:0]);
      if (wr_scr) scratch <= (scratch & ~bm) | (w_q & bm);
      irq_st <= (irq_st & ~(wr_ist ? w_q[1:0] : 2'b00)) | irq_set;
      fc_q <= frame_count_reg;
      ec_nz <= |error_code_reg;
      irq <= |(irq_st & irq_en);
    end
  assign ri = s_axi_araddr[ADDR_W-1:2];
  assign rd_err = ri > W'(OFS_SCRATCH >> 2);
  assign rd_data = hit(ri, OFS_CONTROL)     ? control_reg :
                   hit(ri, OFS_STATUS)      ? status_reg :
                   hit(ri, OFS_FRAME_COUNT) ? frame_count_reg :
                   hit(ri, OFS_ERROR_CODE)  ? error_code_reg :
                   hit(ri, OFS_IRQ_STATUS)  ? {30'd0, irq_st} :
                   hit(ri, OFS_IRQ_ENABLE)  ? {30'd0, irq_en} :
                   hit(ri, OFS_SCRATCH)     ? scratch : 32'd0;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      s_axi_rvalid <= 1'b0;
      s_axi_rdata <= '0;
      s_axi_rresp <= RESP_OKAY;
    end else if (s_axi_arvalid && s_axi_arready) begin
      s_axi_rvalid <= 1'b1;
      s_axi_rdata <= rd_data;
      s_axi_rresp <= rd_err ? RESP_SLVERR : RESP_OKAY;
    end else if (s_axi_rready) s_axi_rvalid <= 1'b0;
endmodule

// File: tb/tb_cnn_axi_lite_regs.sv
// tb_cnn_axi_lite_regs: randomized AXI-Lite traffic checked each cycle against a register-map model
module tb_cnn_axi_lite_regs;
  localparam int AW = 6;
  localparam int P = 4;
  localparam logic [31:0] SR = 32'h5EED_0001;
  logic clk = 0, rst_n = 1;
  logic [AW-1:0] awaddr = 0, araddr = 0;
  logic awvalid = 0, wvalid = 0, bready = 0, arvalid = 0, rready = 0;
  logic [31:0] wdata = 0;
  logic [3:0] wstrb = 0;
  logic awready, wready, bvalid, arready, rvalid, irq;
  logic [1:0] bresp, rresp;
  logic [31:0] rdata, control_reg;
  logic [31:0] status = 0, fcnt = 0, ecode = 0;
  int n = 0, err = 0;
  always #5 clk = ~clk;
  cnn_axi_lite_regs #(.ADDR_W(AW), .PULSE_CYCLES(P), .SCRATCH_RESET(SR)) dut (
    .clk(clk), .rst_n(rst_n),
    .s_axi_awaddr(awaddr), .s_axi_awvalid(awvalid), .s_axi_awready(awready),
    .s_axi_wdata(wdata), .s_axi_wstrb(wstrb), .s_axi_wvalid(wvalid), .s_axi_wready(wready),
    .s_axi_bresp(bresp), .s_axi_bvalid(bvalid), .s_axi_bready(bready),
    .s_axi_araddr(araddr), .s_axi_arvalid(arvalid), .s_axi_arready(arready),
    .s_axi_rdata(rdata), .s_axi_rresp(rresp), .s_axi_rvalid(rvalid), .s_axi_rready(rready),
    .control_reg(control_reg), .status_reg(status), .frame_count_reg(fcnt),
    .error_code_reg(ecode), .irq(irq)
  );
  task automatic chk(input string nm, input logic [31:0] a, input logic [31:0] e);
    n++;
    if (a !== e) begin
      err++;
      $display("FAIL %s: got %h expected %h at %0t", nm, a, e, $time);
    end
  endtask
  task automatic tmo(input int j, input string nm);
    if (j >= 50) begin
      n++;
      err++;
      $display("FAIL %s: handshake timeout at %0t", nm, $time);
    end
  endtask
  // model state: what the register block must hold after each clock edge
  bit m_up, awh, wh, bv, rv, mirq;
  logic [1:0] br, rr, ist, ien;
  logic [31:0] rd_m, hi_m, hd, scr, fcp, ecp;
  logic [3:0] hs;
  logic [AW-1:0] ha;
  int u0, u1, cyc;
  function automatic logic [31:0] mctrl(input int cy);
    return {hi_m[31:2], cy < u1, cy < u0};
  endfunction
  function automatic logic [33:0] rmodel(input logic [AW-1:0] a, input logic [31:0] c);
    case (a[AW-1:2])
      0: return {2'b00, c};
      1: return {2'b00, status};
      2: return {2'b00, fcnt};
      3: return {2'b00, ecode};
      4: return {2'b00, 30'd0, ist};
      5: return {2'b00, 30'd0, ien};
      6: return {2'b00, scr};
      default: return {2'b10, 32'd0};
    endcase
  endfunction
  task automatic step();
    logic [31:0] m, c_old;
    logic [1:0] set, clr;
    bit aw_ok, w_ok, ar_ok, nirq;
    cyc++;
    if (!rst_n) begin
      m_up = 0; awh = 0; wh = 0; bv = 0; rv = 0; br = 0; rr = 0; rd_m = 0;
      hi_m = 0; u0 = 0; u1 = 0; ist = 0; ien = 0; scr = SR; fcp = 0; ecp = 0; mirq = 0;
    end else begin
      c_old = mctrl(cyc - 1);
      aw_ok = m_up && !awh && !bv;
      w_ok = m_up && !wh && !bv;
      ar_ok = m_up && !rv;
      set = {ecode != 0 && ecp == 0, fcnt != fcp};
      clr = 0;
      nirq = |(ist & ien);
      if (arvalid && ar_ok) begin
        rv = 1;
        {rr, rd_m} = rmodel(araddr, c_old);
      end else if (rv && rready) rv = 0;
      if (awh && wh) begin
        m = {{8{hs[3]}}, {8{hs[2]}}, {8{hs[1]}}, {8{hs[0]}}};
        case (ha[AW-1:2])
          0: begin
            hi_m = (hi_m & ~m) | (hd & m);
            if (hs[0]) begin
              u0 = hd[0] ? cyc + P : 0;
              u1 = hd[1] ? cyc + P : 0;
            end
          end
          4: clr = hd[1:0];
          5: ien = (ien & ~m[1:0]) | (hd[1:0] & m[1:0]);
          6: scr = (scr & ~m) | (hd & m);
          default: ;
        endcase
        br = ha[AW-1:2] <= 6 ? 2'b00 : 2'b10;
        bv = 1; awh = 0; wh = 0;
      end else if (bv && bready) bv = 0;
      if (awvalid && aw_ok) begin awh = 1; ha = awaddr; end
      if (wvalid && w_ok) begin wh = 1; hd = wdata; hs = wstrb; end
      ist = (ist & ~clr) | set;
      fcp = fcnt; ecp = ecode; mirq = nirq; m_up = 1;
    end
  endtask
  initial forever begin
    @(posedge clk);
    step();
    #1;
    chk("awready", awready, m_up && !awh && !bv);
    chk("wready", wready, m_up && !wh && !bv);
    chk("arready", arready, m_up && !rv);
    chk("bvalid", bvalid, bv);
    if (bv) chk("bresp", bresp, br);
    chk("rvalid", rvalid, rv);
    if (rv) begin
      chk("rdata", rdata, rd_m);
      chk("rresp", rresp, rr);
    end
    chk("control_reg", control_reg, mctrl(cyc));
    chk("irq", irq, mirq);
  end
  task automatic wr(input logic [AW-1:0] a, input logic [31:0] d, input logic [3:0] s,
                    input int da, input int dw, input int db, output logic [1:0] resp);
    int k;
    fork
      begin
        int j;
        repeat (da) @(negedge clk);
        awaddr = a; awvalid = 1; j = 0;
        while (!awready && j < 50) begin @(negedge clk); j++; end
        tmo(j, "aw");
        @(negedge clk);
        awvalid = 0;
      end
      begin
        int j;
        repeat (dw) @(negedge clk);
        wdata = d; wstrb = s; wvalid = 1; j = 0;
        while (!wready && j < 50) begin @(negedge clk); j++; end
        tmo(j, "w");
        @(negedge clk);
        wvalid = 0;
      end
    join
    k = 0;
    while (!bvalid && k < 50) begin @(negedge clk); k++; end
    tmo(k, "b");
    resp = bresp;
    repeat (db) @(negedge clk);
    bready = 1;
    @(negedge clk);
    bready = 0;
  endtask
  task automatic rd(input logic [AW-1:0] a, input int dr, output logic [31:0] d, output logic [1:0] resp);
    int j;
    araddr = a; arvalid = 1; j = 0;
    while (!arready && j < 50) begin @(negedge clk); j++; end
    tmo(j, "ar");
    @(negedge clk);
    arvalid = 0; j = 0;
    while (!rvalid && j < 50) begin @(negedge clk); j++; end
    tmo(j, "r");
    d = rdata; resp = rresp;
    repeat (dr) @(negedge clk);
    rready = 1;
    @(negedge clk);
    rready = 0;
  endtask
  task automatic count_hi(input int b, input int k, output int c);
    c = 0;
    repeat (k) begin
      @(negedge clk);
      if (control_reg[b]) c++;
    end
  endtask
  initial begin
    logic [31:0] d;
    logic [1:0] r, r2;
    int c;
    fcnt = 4;
    #2 rst_n = 0;
    #1;
    chk("rst awready", awready, 0);
    chk("rst wready", wready, 0);
    chk("rst arready", arready, 0);
    chk("rst bvalid", bvalid, 0);
    chk("rst rvalid", rvalid, 0);
    chk("rst control", control_reg, 0);
    chk("rst irq", irq, 0);
    repeat (3) @(negedge clk);
    rst_n = 1;
    @(negedge clk);
    rd(6'h18, 0, d, r);
    chk("scratch reset", d, SR);
    wr(6'h10, 32'h3, 4'hF, 0, 0, 0, r);
    fork
      wr(6'h00, 32'h1, 4'hF, 0, 0, 0, r);
      count_hi(0, 20, c);
    join
    chk("start bresp", r, 0);
    chk("start width", c, P);
    wr(6'h18, 32'hA5A5_5A5A, 4'hF, 2, 0, 3, r);
    rd(6'h18, 0, d, r);
    chk("scratch full", d, 32'hA5A5_5A5A);
    wr(6'h18, 32'hFFFF_FFFF, 4'h2, 0, 1, 0, r);
    rd(6'h18, 1, d, r);
    chk("scratch strb", d, 32'hA5A5_FF5A);
    wr(6'h14, 32'h1, 4'hF, 0, 0, 0, r);
    @(negedge clk);
    chk("irq idle", irq, 0);
    fcnt = 5;
    @(negedge clk);
    chk("irq lag", irq, 0);
    @(negedge clk);
    chk("irq frame", irq, 1);
    rd(6'h10, 0, d, r);
    chk("irq_status", d, 1);
    wr(6'h10, 32'h1, 4'hF, 0, 0, 0, r);
    chk("irq cleared", irq, 0);
    fork
      wr(6'h10, 32'h1, 4'hF, 0, 0, 0, r);
      begin @(negedge clk); fcnt = 6; end
    join
    rd(6'h10, 0, d, r);
    chk("set beats clear", d, 1);
    status = 32'h2D;
    rd(6'h04, 0, d, r);
    chk("status data", d, 32'h2D);
    chk("status resp", r, 0);
    rd(6'h20, 0, d, r);
    chk("unmapped data", d, 0);
    chk("unmapped resp", r, 2'b10);
    wr(6'h08, 32'hDEAD_BEEF, 4'hF, 0, 0, 0, r);
    chk("ro bresp", r, 0);
    rd(6'h08, 0, d, r);
    chk("ro unchanged", d, 6);
    wr(6'h1C, 32'h1, 4'hF, 0, 0, 0, r);
    chk("unmapped bresp", r, 2'b10);
    fork
      begin wr(6'h00, 32'h1, 4'hF, 0, 0, 0, r); wr(6'h00, 32'h1, 4'hF, 0, 0, 0, r); end
      count_hi(0, 25, c);
    join
    chk("start extend", c, 7);
    fork
      begin wr(6'h00, 32'h1, 4'hF, 0, 0, 0, r); wr(6'h00, 32'h0, 4'hF, 0, 0, 0, r); end
      count_hi(0, 25, c);
    join
    chk("start clear", c, 3);
    awaddr = 0; wdata = 32'h2; wstrb = 4'hF; awvalid = 1; wvalid = 1;
    @(negedge clk);
    awvalid = 0; wvalid = 0;
    @(negedge clk);
    chk("pre-rst bvalid", bvalid, 1);
    chk("pre-rst reset bit", control_reg[1], 1);
    rst_n = 0;
    #1;
    chk("mid-rst bvalid", bvalid, 0);
    chk("mid-rst control", control_reg, 0);
    chk("mid-rst awready", awready, 0);
    chk("mid-rst arready", arready, 0);
    chk("mid-rst bresp", bresp, 0);
    repeat (2) @(negedge clk);
    rst_n = 1;
    @(negedge clk);
    wr(6'h18, 32'h1234_5678, 4'hF, 1, 0, 0, r);
    chk("post-rst bresp", r, 0);
    rd(6'h18, 0, d, r);
    chk("post-rst scratch", d, 32'h1234_5678);
    for (int i = 0; i < 200; i++) begin
      fork
        if ($urandom_range(0, 3) != 0)
          wr(AW'($urandom_range(0, 31)), $urandom, 4'($urandom), $urandom_range(0, 3),
             $urandom_range(0, 3), $urandom_range(0, 3), r);
        if ($urandom_range(0, 1) != 0)
          rd(AW'($urandom_range(0, 31)), $urandom_range(0, 3), d, r2);
        repeat ($urandom_range(1, 6)) begin
          @(negedge clk);
          if ($urandom_range(0, 3) == 0) fcnt = fcnt + 1;
          if ($urandom_range(0, 5) == 0) ecode = $urandom_range(0, 1) != 0 ? 32'd0 : $urandom;
          status = $urandom;
        end
      join
    end
    repeat (5) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n, err);
    $finish;
  end
endmodule

// File: doc/cnn_axi_lite_regs.md
Name: cnn_axi_lite_regs

Overview:
AXI4-Lite slave register front-end that sits between the PS/host AXI interconnect and the CNN control logic. It generates the 32-bit control word, including self-clearing START/RESET bits that the control logic edge-detects. It returns status, frame-count and error-code words to the host on read. It also raises a level interrupt on frame completion or on a new error.

Parameters:
ADDR_W, 5, AXI address width; registers are decoded on addr[ADDR_W-1:2], and addr[1:0] is ignored.
PULSE_CYCLES, 2, number of cycles the START/RESET control bits stay high after a write of 1 (range 1..15).
SCRATCH_RESET, 32'h0, reset value of the SCRATCH register.

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous, active-low reset
s_axi_awaddr  in  ADDR_W  write address
s_axi_awvalid  in  1  write address valid
s_axi_awready  out  1  write address ready
s_axi_wdata  in  32  write data
s_axi_wstrb  in  4  byte enables
s_axi_wvalid  in  1  write data valid
s_axi_wready  out  1  write data ready
s_axi_bresp  out  2  write response
s_axi_bvalid  out  1  write response valid
s_axi_bready  in  1  write response ready
s_axi_araddr  in  ADDR_W  read address
s_axi_arvalid  in  1  read address valid
s_axi_arready  out  1  read address ready
s_axi_rdata  out  32  read data
s_axi_rresp  out  2  read response
s_axi_rvalid  out  1  read data valid
s_axi_rready  in  1  read data ready
control_reg  out  32  control word to the CNN control logic (bit0 START, bit1 RESET)
status_reg  in  32  live status word
frame_count_reg  in  32  processed-frame count
error_code_reg  in  32  current error code
irq  out  1  level interrupt, equal to |(IRQ_STATUS & IRQ_ENABLE)

Behaviour:
- Register map:
  - 0x00 CONTROL: RW.
  - 0x04 STATUS: RO, returns status_reg.
  - 0x08 FRAME_COUNT: RO.
  - 0x0C ERROR_CODE: RO.
  - 0x10 IRQ_STATUS: W1C; bit0 FRAME_DONE, bit1 ERROR.
  - 0x14 IRQ_ENABLE: RW, bits [1:0].
  - 0x18 SCRATCH: RW.
  - 0x1C and above: unmapped.
- Reset values:
  - awready, wready, bvalid, arready, rvalid all 0.
  - bresp, rresp, rdata all 0.
  - control_reg 0, IRQ_STATUS 0, IRQ_ENABLE 0, SCRATCH = SCRATCH_RESET, irq 0.
  - All internal latches are cleared and all pulse counters are 0.
- Write channel:
  - AW and W are accepted independently and in any order; each gets a one-entry holding register.
  - awready = !aw_held && !bvalid; wready = !w_held && !bvalid.
  - The register update happens in the cycle after both halves are held. In that same cycle bvalid rises and both held flags clear.
  - bvalid holds until bready. No new AW/W is accepted while bvalid = 1, so at most one write is outstanding.
  - Minimum latency: AW and W accepted in the same cycle, bvalid one cycle later.
- Write data rules:
  - wstrb applies byte-wise to CONTROL, IRQ_ENABLE and SCRATCH.
  - Writes to RO registers are ignored and respond OKAY (2'b00).
  - Unmapped addresses respond SLVERR (2'b10) with no side effect.
- CONTROL bits 0 and 1:
  - Writing 1 (with wstrb[0] set) sets the bit and loads a per-bit counter with PULSE_CYCLES.
  - The counter decrements each cycle; the bit clears when the counter reaches 0.
  - Writing 1 while the bit is already high reloads the counter, extending the pulse with no gap.
  - Writing 0 clears the bit immediately.
- CONTROL bits [31:2] store the written value unchanged.
- Read channel:
  - arready = !rvalid && !ar_pending.
  - On AR handshake, rdata and rresp are registered and rvalid rises the next cycle; rvalid holds until rready.
  - Reads are single-outstanding.
  - Unmapped reads return rdata = 0 and rresp = SLVERR.
  - A CONTROL read returns the current value, including any self-clearing bits still high.
- Interrupt sources:
  - FRAME_DONE sets when frame_count_reg differs from its value registered one cycle earlier.
  - ERROR sets when error_code_reg goes from 0 to non-zero (previous-cycle compare).
  - A hardware set and a W1C clear of the same bit in the same cycle: set wins, and the bit stays 1.
- irq is registered: it updates one cycle after IRQ_STATUS or IRQ_ENABLE changes.
- Simultaneous read and write: both channels run independently. A read in the same cycle as the CONTROL update returns the pre-write value.
- Reset mid-transaction: all valid and ready outputs drop asynchronously, and any in-flight transaction is discarded.

Decomposition:
- Package cnn_regs_pkg holds:
  - register offsets (OFS_CONTROL through OFS_SCRATCH);
  - RESP_OKAY = 2'b00 and RESP_SLVERR = 2'b10;
  - control bit indices CTRL_CNN_START = 0 and CTRL_CNN_RESET = 1;
  - IRQ bit indices IRQ_FRAME_DONE = 0 and IRQ_ERROR = 1.
- One sub-module, cnn_ctrl_pulse_stretch, instantiated twice (START and RESET). It takes set and clear inputs and PULSE_CYCLES, and produces a level output.

Test Plan:
- AW/W same cycle: write 0x00 = 0x1 with wstrb = 0xF -> bvalid next cycle with bresp = 0; control_reg[0] high for exactly 2 cycles, then 0.
- W two cycles before AW: write 0x18 = 0xA5A5_5A5A with bready held low for 3 cycles -> bvalid holds for 3 cycles, awready/wready stay 0 meanwhile; readback of 0x18 = 0xA5A5_5A5A. Then write 0x18 = 0xFFFF_FFFF with wstrb = 0x2 -> readback 0xA5A5_FF5A.
- Drive frame_count_reg 4->5 with IRQ_ENABLE = 0x1 -> IRQ_STATUS = 0x1 and irq = 1 one cycle later. Write 0x10 = 0x1 -> irq = 0. Repeat the clear in the same cycle as a 5->6 change -> bit remains 1.
- Read 0x04 with status_reg = 0x2D -> rdata = 0x2D, rresp = 0. Read 0x20 -> rdata = 0, rresp = 2'b10. Write 0x08 -> bresp = 0, no change.
- Write START = 1, then again one cycle later -> control_reg[0] stays high for 3 cycles total. Write 0 mid-pulse -> clears the next cycle.
- Assert rst_n low while bvalid = 1 and control_reg[1] is high -> all outputs 0 immediately; after reset, the next write completes normally.
